instruction_controller: RTL and testbench

- Instruction-fetch arbiter between NUM_CORES per-core fetcher blocks and one global-memory instruction channel.
- Grants one fetcher at a time, forwards its PC to memory, and returns the fetched instruction to that fetcher.
- Reports the core being serviced on a one-hot output.
- Sits between the core fetch units and the memory controller.

---
 rtl/inst_ctrl_pkg.sv | 22 ++
 rtl/instruction_controller_rr_arbiter.sv | 54 +++++
 rtl/instruction_controller.sv | 125 ++++++++++++
 tb/tb_instruction_controller.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_ctrl_pkg.sv
// Shared types and defaults for the instruction-fetch controller.
// Holds the FSM state encoding, default parameters and a one-hot helper.
package inst_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_MEM_REQ   = 2'd1,
        ST_MEM_WAIT  = 2'd2,
        ST_CORE_RESP = 2'd3
    } state_t;

    localparam int DEF_NUM_MEM_CHAN   = 1;
    localparam int DEF_NUM_CORES      = 4;
    localparam int DEF_MEM_ADDR_WIDTH = 8;
    localparam int DEF_MEM_DATA_WIDTH = 16;
    localparam int MAX_CORES          = 32;

    function automatic logic [MAX_CORES-1:0] onehot_from_index(input int unsigned idx);
        onehot_from_index = MAX_CORES'(1) << idx;
    endfunction

endpackage

// File: rtl/instruction_controller_rr_arbiter.sv
// Request arbiter for the fetch clients: round-robin from a pointer by default,
// fixed lowest-index priority when INST_CTRL_FIXED_PRIO_EN is defined.
module rr_arbiter
    import inst_ctrl_pkg::*;
#(
    parameter int  NUM_CORES = DEF_NUM_CORES,
    localparam int IDX_W     = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
    input  logic [IDX_W-1:0]     rr_ptr,
    input  logic [NUM_CORES-1:0] req,
    output logic [IDX_W-1:0]     grant_idx,
    output logic                 found,
    output logic [NUM_CORES-1:0] grant_oh
);

    logic [MAX_CORES-1:0] oh_full;
    logic                 unused_oh_hi;

`ifdef INST_CTRL_FIXED_PRIO_EN
    logic unused_rr_ptr;
    assign unused_rr_ptr = ^rr_ptr;

    always_comb begin
        grant_idx = '0;
        found     = 1'b0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (req[i]) begin
                grant_idx = IDX_W'(i);
                found     = 1'b1;
            end
        end
    end
`else
    // Scan downward so the candidate closest to the pointer is written last and wins.
    always_comb begin
        logic [IDX_W-1:0] idx;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        for (int k = NUM_CORES - 1; k >= 0; k--) begin
            idx = IDX_W'((int'(rr_ptr) + k) % NUM_CORES);
            if (req[idx]) begin
                grant_idx = idx;
                found     = 1'b1;
            end
        end
    end
`endif

    assign oh_full      = onehot_from_index(32'(grant_idx));
    assign grant_oh     = found ? oh_full[NUM_CORES-1:0] : '0;
    assign unused_oh_hi = ^oh_full[MAX_CORES-1:NUM_CORES];

endmodule

// File: rtl/instruction_controller.sv
// Arbitrates per-core instruction fetches onto a single memory channel, one
// transaction at a time. Arbitration policy selectable via INST_CTRL_FIXED_PRIO_EN.
module instruction_controller
    import inst_ctrl_pkg::*;
#(
    parameter int  NUM_MEM_CHAN   = DEF_NUM_MEM_CHAN,
    parameter int  NUM_CORES      = DEF_NUM_CORES,
    parameter int  MEM_ADDR_WIDTH = DEF_MEM_ADDR_WIDTH,
    parameter int  MEM_DATA_WIDTH = DEF_MEM_DATA_WIDTH,
    localparam int IDX_W          = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    output logic                      fetch_req_rdy   [NUM_CORES],
    input  logic                      fetch_req_val   [NUM_CORES],
    input  logic [MEM_ADDR_WIDTH-1:0] fetch_req_addr  [NUM_CORES],
    input  logic                      fetch_resp_rdy  [NUM_CORES],
    output logic                      fetch_resp_val  [NUM_CORES],
    output logic [MEM_DATA_WIDTH-1:0] fetch_resp_inst [NUM_CORES],
    input  logic                      mem2fetch_req_rdy,
    output logic                      mem2fetch_req_val,
    output logic [MEM_ADDR_WIDTH-1:0] mem2fetch_req_addr,
    output logic                      mem2fetch_resp_rdy,
    input  logic                      mem2fetch_resp_val,
    input  logic [MEM_DATA_WIDTH-1:0] mem2fetch_resp_inst,
    output logic [NUM_CORES-1:0]      compute_unit
);

    if (NUM_MEM_CHAN != 1 || NUM_CORES < 2 || NUM_CORES >= MAX_CORES) begin : g_param_check
        $error("instruction_controller: unsupported parameter set");
    end

    state_t                    state_q, state_d;
    logic [IDX_W-1:0]          rr_q, grant_q, arb_idx;
    logic [MEM_ADDR_WIDTH-1:0] addr_q;
    logic [MEM_DATA_WIDTH-1:0] inst_q;
    logic [NUM_CORES-1:0]      cu_q, req_vec, arb_oh;
    logic                      arb_found, accept, resp_ack;

    always_comb begin
        for (int i = 0; i < NUM_CORES; i++) req_vec[i] = fetch_req_val[i];
    end

    rr_arbiter #(.NUM_CORES(NUM_CORES)) u_arb (
        .rr_ptr    (rr_q),
        .req       (req_vec),
        .grant_idx (arb_idx),
        .found     (arb_found),
        .grant_oh  (arb_oh)
    );

    // Gating with reset keeps fetch_req_rdy low while reset holds the FSM in IDLE.
    assign accept       = (state_q == ST_IDLE) && arb_found && !reset;
    assign compute_unit = cu_q;

    always_comb begin
        state_d            = state_q;
        resp_ack           = 1'b0;
        mem2fetch_req_val  = 1'b0;
        mem2fetch_req_addr = '0;
        mem2fetch_resp_rdy = 1'b0;
        for (int i = 0; i < NUM_CORES; i++) begin
            fetch_req_rdy[i]   = accept && arb_oh[i];
            fetch_resp_val[i]  = 1'b0;
            fetch_resp_inst[i] = '0;
        end
        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_MEM_REQ;
            end
            ST_MEM_REQ: begin
                mem2fetch_req_val  = 1'b1;
                mem2fetch_req_addr = addr_q;
                if (mem2fetch_req_rdy) state_d = ST_MEM_WAIT;
            end
            ST_MEM_WAIT: begin
                mem2fetch_resp_rdy = 1'b1;
                if (mem2fetch_resp_val) state_d = ST_CORE_RESP;
            end
            ST_CORE_RESP: begin
                // cu_q is the one-hot of the granted core for the whole transaction.
                for (int i = 0; i < NUM_CORES; i++) begin
                    fetch_resp_val[i]  = cu_q[i];
                    fetch_resp_inst[i] = cu_q[i] ? inst_q : '0;
                    resp_ack           = resp_ack | (cu_q[i] & fetch_resp_rdy[i]);
                end
                if (resp_ack) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            rr_q    <= '0;
            grant_q <= '0;
            addr_q  <= '0;
            inst_q  <= '0;
            cu_q    <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        addr_q  <= fetch_req_addr[arb_idx];
                        grant_q <= arb_idx;
                        cu_q    <= arb_oh;
                    end
                end
                ST_MEM_WAIT: begin
                    if (mem2fetch_resp_val) inst_q <= mem2fetch_resp_inst;
                end
                ST_CORE_RESP: begin
                    if (resp_ack) begin
                        rr_q <= (grant_q == IDX_W'(NUM_CORES - 1)) ? '0 : grant_q + 1'b1;
                        cu_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_controller.sv
// Self-checking bench for instruction_controller: directed scenarios plus
// randomized fetch traffic checked against a transaction-level arbitration model.
module tb_instruction_controller;

    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          fetch_req_rdy   [N];
    logic          fetch_req_val   [N];
    logic [AW-1:0] fetch_req_addr  [N];
    logic          fetch_resp_rdy  [N];
    logic          fetch_resp_val  [N];
    logic [DW-1:0] fetch_resp_inst [N];
    logic          mem2fetch_req_rdy;
    logic          mem2fetch_req_val;
    logic [AW-1:0] mem2fetch_req_addr;
    logic          mem2fetch_resp_rdy;
    logic          mem2fetch_resp_val;
    logic [DW-1:0] mem2fetch_resp_inst;
    logic [N-1:0]  compute_unit;

    instruction_controller dut (
        .clk                 (clk),
        .reset               (reset),
        .fetch_req_rdy       (fetch_req_rdy),
        .fetch_req_val       (fetch_req_val),
        .fetch_req_addr      (fetch_req_addr),
        .fetch_resp_rdy      (fetch_resp_rdy),
        .fetch_resp_val      (fetch_resp_val),
        .fetch_resp_inst     (fetch_resp_inst),
        .mem2fetch_req_rdy   (mem2fetch_req_rdy),
        .mem2fetch_req_val   (mem2fetch_req_val),
        .mem2fetch_req_addr  (mem2fetch_req_addr),
        .mem2fetch_resp_rdy  (mem2fetch_resp_rdy),
        .mem2fetch_resp_val  (mem2fetch_resp_val),
        .mem2fetch_resp_inst (mem2fetch_resp_inst),
        .compute_unit        (compute_unit)
    );

    always #5 clk = ~clk;

    int            errors   = 0;
    int            checks   = 0;
    int            rr_model = 0;
    logic [N-1:0]  pend     = '0;
    logic [AW-1:0] paddr [N];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Winner among pending cores under the selected policy.
    function automatic int pick(input logic [N-1:0] p, input int rr);
`ifdef INST_CTRL_FIXED_PRIO_EN
        for (int k = 0; k < N; k++) if (p[k]) return k;
`else
        for (int k = 0; k < N; k++) if (p[(rr + k) % N]) return (rr + k) % N;
`endif
        return -1;
    endfunction

    function automatic logic [N-1:0] v_req_rdy();
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = fetch_req_rdy[i];
        return r;
    endfunction

    function automatic logic [N-1:0] v_resp_val();
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = fetch_resp_val[i];
        return r;
    endfunction

    function automatic logic [31:0] activity();
        logic [31:0] a;
        a = '0;
        for (int i = 0; i < N; i++) begin
            a[0] = a[0] | fetch_req_rdy[i];
            a[1] = a[1] | fetch_resp_val[i];
            a[2] = a[2] | (fetch_resp_inst[i] != '0);
        end
        a[3]    = mem2fetch_req_val;
        a[4]    = |mem2fetch_req_addr;
        a[5]    = mem2fetch_resp_rdy;
        a[11:8] = compute_unit;
        return a;
    endfunction

    task automatic drive_reqs();
        for (int i = 0; i < N; i++) begin
            fetch_req_val[i]  = pend[i];
            fetch_req_addr[i] = paddr[i];
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One full fetch transaction with the given memory/core stall lengths.
    task automatic do_txn(input int mdly, input int rdly, input int cdly,
                          input logic [DW-1:0] inst, output int w);
        logic [AW-1:0] a;
        logic [DW-1:0] other;
        w = pick(pend, rr_model);
        if (w < 0) begin
            check("model_has_request", 32'(pend), 32'h1);
            return;
        end
        a = paddr[w];
        drive_reqs();
        #1;
        check("req_rdy_grant", 32'(v_req_rdy()), 32'(1 << w));
        check("cu_idle", 32'(compute_unit), 0);
        next_cycle();
        pend[w] = 1'b0;
        drive_reqs();
        for (int c = 0; c <= mdly; c++) begin
            mem2fetch_req_rdy   = (c == mdly);
            mem2fetch_resp_val  = (c < mdly);
            mem2fetch_resp_inst = ~inst;
            #1;
            check("cu_grant", 32'(compute_unit), 32'(1 << w));
            check("mreq_val", 32'(mem2fetch_req_val), 1);
            check("mreq_addr", 32'(mem2fetch_req_addr), 32'(a));
            check("req_rdy_busy", 32'(v_req_rdy()), 0);
            check("mresp_rdy_early", 32'(mem2fetch_resp_rdy), 0);
            next_cycle();
        end
        mem2fetch_req_rdy = 1'b0;
        for (int c = 0; c <= rdly; c++) begin
            mem2fetch_resp_val  = (c == rdly);
            mem2fetch_resp_inst = (c == rdly) ? inst : DW'($urandom);
            #1;
            check("mresp_rdy", 32'(mem2fetch_resp_rdy), 1);
            check("mreq_val_wait", 32'(mem2fetch_req_val), 0);
            check("mreq_addr_wait", 32'(mem2fetch_req_addr), 0);
            check("resp_val_early", 32'(v_resp_val()), 0);
            next_cycle();
        end
        mem2fetch_resp_val  = 1'b0;
        mem2fetch_resp_inst = '0;
        for (int c = 0; c <= cdly; c++) begin
            for (int i = 0; i < N; i++)
                fetch_resp_rdy[i] = (i == w) ? (c == cdly) : 1'($urandom_range(1, 0));
            #1;
            other = '0;
            for (int i = 0; i < N; i++) if (i != w) other = other | fetch_resp_inst[i];
            check("resp_val", 32'(v_resp_val()), 32'(1 << w));
            check("resp_inst", 32'(fetch_resp_inst[w]), 32'(inst));
            check("resp_inst_other", 32'(other), 0);
            check("cu_resp", 32'(compute_unit), 32'(1 << w));
            check("req_rdy_resp", 32'(v_req_rdy()), 0);
            next_cycle();
        end
        for (int i = 0; i < N; i++) fetch_resp_rdy[i] = 1'b0;
        #1;
        check("cu_done", 32'(compute_unit), 0);
        check("resp_val_done", 32'(v_resp_val()), 0);
        rr_model = (w + 1) % N;
    endtask

    initial begin
        int w;
        int k;
        reset               = 1'b1;
        mem2fetch_req_rdy   = 1'b0;
        mem2fetch_resp_val  = 1'b0;
        mem2fetch_resp_inst = '0;
        for (int i = 0; i < N; i++) begin
            paddr[i]          = '0;
            fetch_resp_rdy[i] = 1'b0;
        end
        drive_reqs();
        @(negedge clk);
        #1;
        check("reset_outputs", activity(), 0);
        reset = 1'b0;

        // All four cores requesting continuously.
        pend = '1;
        for (int i = 0; i < N; i++) paddr[i] = AW'(8'h10 + i);
        for (int t = 0; t < 5; t++) begin
            do_txn(0, 0, 0, DW'(16'hA000 + t), w);
            pend[w] = 1'b1;
        end

        // Single request from core 2.
        pend = 4'b0100;
        paddr[2] = 8'h14;
        do_txn(0, 0, 0, 16'hBEEF, w);
        check("single_winner", 32'(w), 2);

        // Backpressure on memory request and core response with core 2 waiting.
        pend = 4'b0110;
        paddr[1] = 8'h5A;
        paddr[2] = 8'h77;
        do_txn(3, 1, 2, 16'h1234, w);

        // Wrap-around after serving core 3.
        pend = 4'b1000;
        paddr[3] = 8'hC3;
        do_txn(0, 0, 0, 16'h3333, w);
        pend = 4'b1001;
        paddr[0] = 8'h0F;
        do_txn(0, 0, 0, 16'h0F0F, w);
        check("wrap_winner", 32'(w), 0);

        // Reset while waiting on memory; arbitration restarts from pointer 0.
        pend = 4'b0010;
        paddr[1] = 8'h21;
        do_txn(0, 0, 0, 16'h2121, w);
        pend = 4'b1000;
        paddr[3] = 8'h3C;
        drive_reqs();
        #1;
        check("pre_reset_grant", 32'(v_req_rdy()), 32'(1 << pick(pend, rr_model)));
        next_cycle();
        pend = '0;
        drive_reqs();
        mem2fetch_req_rdy = 1'b1;
        next_cycle();
        mem2fetch_req_rdy = 1'b0;
        #1;
        check("in_mem_wait", 32'(mem2fetch_resp_rdy), 1);
        pend = 4'b0010;
        paddr[1] = 8'h51;
        drive_reqs();
        reset = 1'b1;
        #1;
        check("reset_async_outputs", activity(), 0);
        next_cycle();
        #1;
        check("reset_held_outputs", activity(), 0);
        reset    = 1'b0;
        rr_model = 0;
        pend     = 4'b1010;
        paddr[3] = 8'h3D;
        do_txn(1, 1, 1, 16'h5151, w);
        check("post_reset_winner", 32'(w), 1);

        // Idle: nothing requested for 10 cycles.
        pend = '0;
        drive_reqs();
        for (int c = 0; c < 10; c++) begin
            next_cycle();
            #1;
            check("idle_outputs", activity(), 0);
        end

        // Randomized traffic.
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(1, 0) == 1) begin
                    pend[i]  = 1'b1;
                    paddr[i] = AW'($urandom);
                end
            end
            if (pend == '0) begin
                k = int'($urandom_range(N - 1, 0));
                pend[k]  = 1'b1;
                paddr[k] = AW'($urandom);
            end
            do_txn(int'($urandom_range(3, 0)), int'($urandom_range(3, 0)),
                   int'($urandom_range(3, 0)), DW'($urandom), w);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
